// File: rtl/mux_rr_param.sv
// mux_rr_param: NCH-channel word multiplexer with a registered output stage.
//
// Build options:
//   MUX_RR_PARAM_ROUND_ROBIN_EN defined   -> round-robin arbitration.
//                                             selector is ignored and sel_err stays 0.
//   MUX_RR_PARAM_ROUND_ROBIN_EN undefined -> fixed-select mode (default).
//                                             The channel is picked by selector.
//
// Parameters:
//   WIDTH  data bits per channel (1..32)
//   NCH    number of input channels (2..8)
//   SELW   grant index width, 2**SELW >= NCH
//
// Ports:
//   clk            sole clock, rising edge
//   reset          synchronous, active-high
//   in_data        channel k data at [k*WIDTH +: WIDTH]
//   in_valid       bit k high = channel k holds a word
//   selector       channel index used in fixed-select mode
//   out_ready      downstream can accept a word this cycle
//   pop            combinational one-hot, channel word consumed this cycle
//   data_out       registered word; 0 when there was no transfer
//   valid_bit_out  registered; high = data_out is a new word
//   sel_out        registered index of the last delivering channel
//   sel_err        registered sticky flag: out-of-range selector seen
module mux_rr_param #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  input  logic [SELW-1:0]      selector,
  input  logic                 out_ready,
  output logic [NCH-1:0]       pop,
  output logic [WIDTH-1:0]     data_out,
  output logic                 valid_bit_out,
  output logic [SELW-1:0]      sel_out,
  output logic                 sel_err
);

  logic             w_grant_vld;
  logic [SELW-1:0]  w_grant_idx;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [SELW-1:0]  r_sel;
  logic             r_sel_err;

`ifdef MUX_RR_PARAM_ROUND_ROBIN_EN
  logic [SELW-1:0]  r_last;
  int               w_cand;
  logic             w_unused_sel;

  assign w_unused_sel = ^selector;

  // The search runs from the farthest offset down to the nearest one.
  // The nearest valid channel after r_last is assigned last, so it wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = 0;
    for (int off = NCH; off >= 1; off--) begin
      w_cand = int'(r_last) + off;
      if (w_cand >= NCH) w_cand = w_cand - NCH;
      if (in_valid[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = SELW'(w_cand);
      end
    end
  end
`else
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      if (selector == SELW'(k) && in_valid[k]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = SELW'(k);
      end
    end
  end
`endif

  assign w_xfer = w_grant_vld & out_ready & ~reset;

  always_comb begin
    pop    = '0;
    w_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (w_grant_idx == SELW'(k)) begin
        pop[k] = w_xfer;
        w_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_sel     <= '0;
      r_sel_err <= 1'b0;
`ifdef MUX_RR_PARAM_ROUND_ROBIN_EN
      // Starting from NCH-1 lets channel 0 win the first arbitration.
      r_last    <= SELW'(NCH - 1);
`endif
    end else begin
      r_valid <= w_xfer;
      r_data  <= w_xfer ? w_data : '0;
      if (w_xfer) r_sel <= w_grant_idx;
`ifdef MUX_RR_PARAM_ROUND_ROBIN_EN
      if (w_xfer) r_last <= w_grant_idx;
      r_sel_err <= 1'b0;
`else
      if (out_ready && int'(selector) >= NCH) r_sel_err <= 1'b1;
`endif
    end
  end

  assign data_out      = r_data;
  assign valid_bit_out = r_valid;
  assign sel_out       = r_sel;
  assign sel_err       = r_sel_err;

endmodule

// File: tb/tb_mux_rr_param.sv
module tb_mux_rr_param;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic [1:0]  selector;
  logic        out_ready;
  logic [3:0]  pop;
  logic [3:0]  data_out;
  logic        valid_bit_out;
  logic [1:0]  sel_out;
  logic        sel_err;

  logic [2:0]  pop3;
  logic [3:0]  data_out3;
  logic        valid_bit_out3;
  logic [1:0]  sel_out3;
  logic        sel_err3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_rr_param #(.WIDTH(4), .NCH(4), .SELW(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .selector(selector), .out_ready(out_ready), .pop(pop),
    .data_out(data_out), .valid_bit_out(valid_bit_out),
    .sel_out(sel_out), .sel_err(sel_err)
  );

  mux_rr_param #(.WIDTH(4), .NCH(3), .SELW(2)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data[11:0]), .in_valid(in_valid[2:0]),
    .selector(selector), .out_ready(out_ready), .pop(pop3),
    .data_out(data_out3), .valid_bit_out(valid_bit_out3),
    .sel_out(sel_out3), .sel_err(sel_err3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs are already applied. Check pop before the edge and the registered outputs after it.
  task automatic step(input string tag, input logic [3:0] e_pop, input logic e_v,
                      input logic [3:0] e_d, input logic [1:0] e_s);
    #1;
    chk({tag, ".pop"}, 32'(pop), 32'(e_pop));
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(valid_bit_out), 32'(e_v));
    chk({tag, ".data"},  32'(data_out), 32'(e_d));
    chk({tag, ".sel"},   32'(sel_out), 32'(e_s));
  endtask

  initial begin
    // ch0=1, ch1=2, ch2=A, ch3=3
    in_data   = 16'h3A21;
    reset     = 1'b1;
    in_valid  = 4'b0100;
    selector  = 2'd2;
    out_ready = 1'b1;
    #1;
    chk("rst.pop", 32'(pop), 0);
    chk("rst.pop3", 32'(pop3), 0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst.valid", 32'(valid_bit_out), 0);
    chk("rst.data", 32'(data_out), 0);
    chk("rst.sel", 32'(sel_out), 0);
    chk("rst.err", 32'(sel_err), 0);
    chk("rst.err3", 32'(sel_err3), 0);

    reset    = 1'b0;
    in_valid = 4'b0000;
    for (int i = 0; i < 3; i++) step("idle", 4'b0000, 1'b0, 4'h0, 2'd0);

`ifdef MUX_RR_PARAM_ROUND_ROBIN_EN
    in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] d;
      d = in_data[(i%4)*4 +: 4];
      step("rr_all", 4'(1 << (i % 4)), 1'b1, d, 2'(i % 4));
    end
    in_valid = 4'b0010;
    step("rr_g1", 4'b0010, 1'b1, 4'h2, 2'd1);
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("rr_stall", 4'b0000, 1'b0, 4'h0, 2'd1);
    out_ready = 1'b1;
    step("rr_resume", 4'b0100, 1'b1, 4'hA, 2'd2);
    in_valid = 4'b1000;
    selector = 2'd3;
    for (int i = 0; i < 3; i++) step("rr_single", 4'b1000, 1'b1, 4'h3, 2'd3);
    chk("rr.err", 32'(sel_err), 0);
    chk("rr.err3", 32'(sel_err3), 0);
    in_valid = 4'b1111;
    reset    = 1'b1;
    step("rr_rst", 4'b0000, 1'b0, 4'h0, 2'd0);
    reset = 1'b0;
    step("rr_first", 4'b0001, 1'b1, 4'h1, 2'd0);
`else
    selector = 2'd2;
    in_valid = 4'b0100;
    step("fx_ch2", 4'b0100, 1'b1, 4'hA, 2'd2);
    selector = 2'd1;
    in_valid = 4'b0001;
    step("fx_miss", 4'b0000, 1'b0, 4'h0, 2'd2);
    selector  = 2'd3;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    step("fx_stall", 4'b0000, 1'b0, 4'h0, 2'd2);
    chk("fx.err3_stall", 32'(sel_err3), 0);
    out_ready = 1'b1;
    #1;
    chk("fx.pop3_oob", 32'(pop3), 0);
    step("fx_ch3", 4'b1000, 1'b1, 4'h3, 2'd3);
    chk("fx.err3_set", 32'(sel_err3), 1);
    chk("fx.err4", 32'(sel_err), 0);
    selector = 2'd0;
    step("fx_ch0", 4'b0001, 1'b1, 4'h1, 2'd0);
    chk("fx.err3_sticky", 32'(sel_err3), 1);
    reset = 1'b1;
    step("fx_rst", 4'b0000, 1'b0, 4'h0, 2'd0);
    chk("fx.err3_clr", 32'(sel_err3), 0);
    reset = 1'b0;
    step("fx_after", 4'b0001, 1'b1, 4'h1, 2'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_rr_param.md
MUX_RR_PARAM -- requirements
Module: mux_rr_param

Interface
REQ-001 Parameter WIDTH, default 4: data bits per channel (1..32).
REQ-002 Parameter NCH, default 4: number of input channels (2..8).
REQ-003 Parameter SELW, default 2: selector/grant index width, SHALL satisfy 2**SELW >= NCH.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  NCH*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
REQ-007 in_valid  input  NCH  bit k high = channel k holds a word.
REQ-008 selector  input  SELW  channel index for fixed-select mode.
REQ-009 out_ready  input  1  downstream can accept a word this cycle.
REQ-010 pop  output  NCH  combinational one-hot; bit k high = channel k word consumed this cycle.
REQ-011 data_out  output  WIDTH  registered output word.
REQ-012 valid_bit_out  output  1  registered; high = data_out is a new word.
REQ-013 sel_out  output  SELW  registered index of the channel delivering data_out.
REQ-014 sel_err  output  1  registered sticky flag: out-of-range selector seen.

Function
REQ-015 Per cycle at most one channel SHALL be granted; a transfer occurs iff granted channel's in_valid=1 and out_ready=1 and reset=0.
REQ-016 On transfer, pop SHALL assert for the granted channel only, in the same cycle; otherwise pop = 0.
REQ-017 Latency: word transferred in cycle N SHALL appear on data_out with valid_bit_out=1 and sel_out=index in cycle N+1.
REQ-018 Cycle with no transfer: next cycle valid_bit_out=0, data_out=0, sel_out holds previous value.
REQ-019 out_ready=0: no pop, no grant-pointer update, input words not lost (remain for upstream).
REQ-020 Fixed mode: grant = selector if selector < NCH and in_valid[selector]=1; else no grant.
REQ-021 selector >= NCH with out_ready=1 SHALL set sel_err next cycle; sel_err clears only on reset.
REQ-022 Round-robin mode: 2-bit-wide-independent pointer last (SELW bits); search order last+1, last+2, ... modulo NCH, ending with last; first valid channel granted.
REQ-023 last SHALL update to granted index only on transfer; wrap from NCH-1 to 0.
REQ-024 Single valid channel in round-robin SHALL be granted every cycle (back-to-back) while out_ready=1.
REQ-025 in_valid change or selector change takes effect the same cycle (grant is combinational on current inputs).

Reset
REQ-026 reset=1 at a clock edge: data_out=0, valid_bit_out=0, sel_out=0, sel_err=0, last=NCH-1 (so channel 0 wins first).
REQ-027 While reset=1, pop SHALL be 0; reset mid-stream discards the registered word, upstream words untouched.

Configuration
REQ-028 Macro MUX_RR_PARAM_ROUND_ROBIN_EN defined: round-robin arbitration (REQ-022..024); selector ignored, sel_err held 0.
REQ-029 Macro undefined: fixed-select mode (REQ-020..021); pointer last absent; all other behaviour identical.

Verification
REQ-030 Reset 2 cycles, then all in_valid=0 -> data_out=0, valid_bit_out=0, sel_out=0, pop=0 every cycle.
REQ-031 Fixed, WIDTH=4 NCH=4: selector=2, in_valid=4'b0100, in_data ch2=4'hA, out_ready=1 -> pop=4'b0100 cycle N; data_out=4'hA, valid_bit_out=1, sel_out=2 cycle N+1.
REQ-032 Fixed: selector=1, in_valid[1]=0, ch0 valid -> no pop, next cycle valid_bit_out=0, data_out=0 (ch0 not served).
REQ-033 Round-robin: in_valid=4'b1111 held, out_ready=1, 8 cycles -> sel_out sequence 0,1,2,3,0,1,2,3 with valid_bit_out=1 throughout.
REQ-034 Round-robin: grant ch1, then out_ready=0 for 3 cycles, then 1 with in_valid=4'b1111 -> no pops while stalled, valid_bit_out=0, next grant ch2.
REQ-035 Fixed, NCH=3 SELW=2: selector=3, out_ready=1 -> pop=0, sel_err=1 next cycle, stays 1 until reset asserted.
